// File: rtl/lcd_text_buffer.sv
// lcd_text_buffer: byte stream to 2x16 LCD text buffer with cursor and control codes.
// Define LCD_TEXT_SCROLL_EN to scroll on line break from the bottom row; otherwise the cursor wraps to (0,0).
module lcd_text_buffer (
  input  logic         clk,
  input  logic         rst,
  input  logic         ch_valid,
  input  logic [7:0]   ch_data,
  output logic         ch_ready,
  output logic [127:0] row_a,
  output logic [127:0] row_b,
  output logic         cur_row,
  output logic [3:0]   cur_col,
  output logic         busy
);
`ifdef LCD_TEXT_SCROLL_EN
  typedef enum logic [1:0] {IDLE, CLEAR, SCROLL} state_e;
`else
  typedef enum logic [1:0] {IDLE, CLEAR} state_e;
`endif
  state_e state_q, state_d;
  // packed [0:15] keeps column 0 in the most significant byte of each row
  logic [0:1][0:15][7:0] buf_q, buf_d;
  logic       row_q, row_d;
  logic [3:0] col_q, col_d, col_m1;
  logic [4:0] idx_q, idx_d;
  logic       lb;
  assign ch_ready = state_q == IDLE;
  assign busy     = ~ch_ready;
  assign row_a    = buf_q[0];
  assign row_b    = buf_q[1];
  assign cur_row  = row_q;
  assign cur_col  = col_q;
  assign col_m1   = col_q - 4'd1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= {32{8'h20}};
      row_q   <= 1'b0;
      col_q   <= 4'd0;
      idx_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      row_q   <= row_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
    end
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    row_d   = row_q;
    col_d   = col_q;
    idx_d   = idx_q;
    lb      = 1'b0;
    case (state_q)
      IDLE: if (ch_valid) begin
        if (ch_data >= 8'h20 && ch_data <= 8'h7E) begin
          buf_d[row_q][col_q] = ch_data;
          if (col_q != 4'd15) col_d = col_q + 4'd1;
          else lb = 1'b1;
        end else if (ch_data == 8'h0A) lb = 1'b1;
        else if (ch_data == 8'h0C) begin
          state_d = CLEAR;
          idx_d   = 5'd0;
        end else if (ch_data == 8'h08) begin
          if (col_q != 4'd0) begin
            col_d = col_m1;
            buf_d[row_q][col_m1] = 8'h20;
          end else if (row_q) begin
            row_d = 1'b0;
            col_d = 4'd15;
            buf_d[0][15] = 8'h20;
          end
        end
        if (lb) begin
          if (!row_q) begin
            row_d = 1'b1;
            col_d = 4'd0;
          end else begin
`ifdef LCD_TEXT_SCROLL_EN
            state_d = SCROLL;
            idx_d   = 5'd0;
`else
            row_d = 1'b0;
            col_d = 4'd0;
`endif
          end
        end
      end
      CLEAR: begin
        buf_d[idx_q[4]][idx_q[3:0]] = 8'h20;
        idx_d = idx_q + 5'd1;
        if (idx_q == 5'd31) begin
          state_d = IDLE;
          row_d   = 1'b0;
          col_d   = 4'd0;
        end
      end
`ifdef LCD_TEXT_SCROLL_EN
      SCROLL: begin
        buf_d[0][idx_q[3:0]] = buf_q[1][idx_q[3:0]];
        buf_d[1][idx_q[3:0]] = 8'h20;
        idx_d = idx_q + 5'd1;
        if (idx_q[3:0] == 4'd15) begin
          state_d = IDLE;
          row_d   = 1'b1;
          col_d   = 4'd0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_lcd_text_buffer.sv
// tb_lcd_text_buffer: randomized and directed checks of lcd_text_buffer against a linear-cursor text model.
module tb_lcd_text_buffer;
  logic clk, rst, ch_valid, ch_ready, cur_row, busy;
  logic [7:0] ch_data;
  logic [127:0] row_a, row_b;
  logic [3:0] cur_col;
  int pass_cnt = 0, total = 0, exp_busy = 0;
  logic [7:0] mem [32];
  logic [4:0] pos;

  lcd_text_buffer dut (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
    .row_a(row_a), .row_b(row_b), .cur_row(cur_row), .cur_col(cur_col), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) mem[i] = 8'h20;
    pos = 5'd0;
  endfunction

  function automatic int line_break();
    if (pos < 5'd16) begin pos = 5'd16; return 0; end
`ifdef LCD_TEXT_SCROLL_EN
    for (int i = 0; i < 16; i++) begin mem[i] = mem[i+16]; mem[i+16] = 8'h20; end
    pos = 5'd16;
    return 16;
`else
    pos = 5'd0;
    return 0;
`endif
  endfunction

  function automatic int apply(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      mem[pos] = b;
      if (pos == 5'd31) return line_break();
      pos = pos + 5'd1;
      return 0;
    end
    if (b == 8'h0A) return line_break();
    if (b == 8'h0C) begin model_reset(); return 32; end
    if (b == 8'h08 && pos != 5'd0) begin pos = pos - 5'd1; mem[pos] = 8'h20; end
    return 0;
  endfunction

  function automatic logic [261:0] exp_vec();
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[255-8*i -: 8] = mem[i];
    return {r, pos[4], pos[3:0], 1'b0};
  endfunction

  task automatic send(input logic [7:0] b, output int waited);
    ch_data = b; ch_valid = 1'b1; waited = 0;
    while (!ch_ready && waited < 100) begin @(posedge clk); #1; waited++; end
    @(posedge clk); #1;
    ch_valid = 1'b0;
    exp_busy = apply(b);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ch_ready && n < 100) begin @(posedge clk); #1; n++; end
  endtask

  task automatic do_reset();
    rst = 1'b1; ch_valid = 1'b0; ch_data = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({row_a, row_b, cur_row, cur_col, busy} !== exp_vec() || ch_ready !== 1'b1)
      $display("FAIL reset got=%h exp=%h", {row_a, row_b, cur_row, cur_col, busy}, exp_vec());
    else pass_cnt++;
  endtask

  task automatic test_hello();
    logic [39:0] s = 40'h48454C4C4F;
    int w;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(s[39-8*i -: 8], w);
      total++;
      if ({row_a, row_b, cur_row, cur_col, busy} !== exp_vec() || w != 0 || ch_ready !== 1'b1)
        $display("FAIL hello_%0d got=%h exp=%h wait=%0d", i, {row_a, row_b, cur_row, cur_col, busy}, exp_vec(), w);
      else pass_cnt++;
    end
    total++;
    if (row_a[127:88] !== 40'h48454C4C4F || cur_col !== 4'd5)
      $display("FAIL hello_text got=%h col=%0d exp=48454c4c4f col=5", row_a[127:88], cur_col);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    int w;
    do_reset();
    for (int i = 0; i < 17; i++) send(8'h41, w);
    total++;
    if (row_a !== {16{8'h41}} || row_b !== {8'h41, {15{8'h20}}} || cur_row !== 1'b1 || cur_col !== 4'd1)
      $display("FAIL wrap got=%h %h cur=%0d,%0d exp=row_a all 41, cur=1,1", row_a, row_b, cur_row, cur_col);
    else pass_cnt++;
  endtask

  task automatic test_scroll();
    int w, n;
    do_reset();
    for (int i = 0; i < 32; i++) send(8'h42, w);
    wait_ready(n);
    total++;
    if (n != exp_busy)
      $display("FAIL scroll_busy got=%0d exp=%0d", n, exp_busy);
    else pass_cnt++;
    send(8'h43, w);
    total++;
`ifdef LCD_TEXT_SCROLL_EN
    if (n != 16 || row_a !== {16{8'h42}} || row_b !== {8'h43, {15{8'h20}}} || cur_row !== 1'b1 || cur_col !== 4'd1)
      $display("FAIL scroll got=%h %h cur=%0d,%0d busy=%0d", row_a, row_b, cur_row, cur_col, n);
`else
    if (n != 0 || row_a !== {8'h43, {15{8'h42}}} || row_b !== {16{8'h42}} || cur_row !== 1'b0 || cur_col !== 4'd1)
      $display("FAIL wrap_top got=%h %h cur=%0d,%0d busy=%0d", row_a, row_b, cur_row, cur_col, n);
`endif
    else pass_cnt++;
  endtask

  task automatic test_backspace();
    logic [7:0] seq [7] = '{8'h58, 8'h59, 8'h08, 8'h08, 8'h08, 8'h0A, 8'h0A};
    int w, n;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      send(seq[i], w);
      wait_ready(n);
      total++;
      if ({row_a, row_b, cur_row, cur_col, busy} !== exp_vec() || n != exp_busy)
        $display("FAIL bs_%0d got=%h exp=%h busy=%0d/%0d", i, {row_a, row_b, cur_row, cur_col, busy}, exp_vec(), n, exp_busy);
      else pass_cnt++;
    end
  endtask

  task automatic test_clear();
    int w;
    do_reset();
    for (int i = 0; i < 20; i++) send(8'($urandom_range(8'h21, 8'h7E)), w);
    send(8'h0C, w);
    send(8'h5A, w);
    total++;
    if (w != 32 || {row_a, row_b, cur_row, cur_col, busy} !== exp_vec() || row_a[127:120] !== 8'h5A)
      $display("FAIL clear got=%h exp=%h wait=%0d exp_wait=32", {row_a, row_b, cur_row, cur_col, busy}, exp_vec(), w);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int w;
    do_reset();
    for (int i = 0; i < 8; i++) send(8'h4D, w);
    send(8'h0C, w);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1 model_reset();
    total++;
    if ({row_a, row_b, cur_row, cur_col, busy} !== exp_vec() || ch_ready !== 1'b1)
      $display("FAIL reset_mid got=%h exp=%h", {row_a, row_b, cur_row, cur_col, busy}, exp_vec());
    else pass_cnt++;
    @(posedge clk); #1 rst = 1'b0;
    send(8'h07, w);
    total++;
    if ({row_a, row_b, cur_row, cur_col, busy} !== exp_vec())
      $display("FAIL ignore_07 got=%h exp=%h", {row_a, row_b, cur_row, cur_col, busy}, exp_vec());
    else pass_cnt++;
  endtask

  task automatic test_random();
    int w, n, r;
    logic [7:0] b;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 39);
      b = r < 28 ? 8'($urandom_range(8'h20, 8'h7E)) : r < 32 ? 8'h0A : r < 36 ? 8'h08 :
          r < 37 ? 8'h0C : 8'($urandom_range(8'h7F, 8'hFF));
      send(b, w);
      wait_ready(n);
      total++;
      if ({row_a, row_b, cur_row, cur_col, busy} !== exp_vec() || n != exp_busy)
        $display("FAIL rand_%0d byte=%h got=%h exp=%h busy=%0d/%0d", i, b, {row_a, row_b, cur_row, cur_col, busy}, exp_vec(), n, exp_busy);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; ch_valid = 1'b0; ch_data = 8'h00;
    #1;
    test_reset();
    test_hello();
    test_wrap();
    test_scroll();
    test_backspace();
    test_clear();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/lcd_text_buffer.md
# lcd_text_buffer

Character-stream front end for the 2×16 character LCD driver. It accepts ASCII bytes over a valid/ready handshake and interprets a small set of control codes. It maintains a 32-cell text buffer with a cursor. The buffer is presented as two flattened 128-bit row vectors wired directly to the LCD driver's row inputs, which the driver refreshes continuously.

## Interface
- No parameters; geometry is fixed at 2 rows × 16 columns × 8-bit ASCII.
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- ch_valid  in  1  ch_data holds a byte to consume
- ch_data  in  8  ASCII byte or control code
- ch_ready  out  1  block can accept a byte this cycle
- row_a  out  128  top row; column 0 in [127:120], column 15 in [7:0]
- row_b  out  128  bottom row; same packing as row_a
- cur_row  out  1  cursor row (0 = top)
- cur_col  out  4  cursor column
- busy  out  1  multi-cycle operation (CLEAR/SCROLL) in progress; equals ~ch_ready

## Operation
- Transfer occurs on a rising clk when ch_valid && ch_ready. When ch_ready is low, ch_data is ignored. The producer holds ch_valid/ch_data until the transfer.
- States: IDLE, CLEAR, SCROLL. ch_ready = (state == IDLE).
- Byte decode in IDLE:
  - 0x20–0x7E (printable): write the byte to cell (cur_row, cur_col), then advance the cursor.
  - 0x0A (newline): perform a line break (below).
  - 0x0C (form feed): enter CLEAR.
  - 0x08 (backspace):
    - If cur_col > 0: cur_col−1, then write 0x20 at the new position.
    - Else if cur_row = 1: go to (0,15), then write 0x20 there.
    - At (0,0): no-op.
  - All other codes: consumed and ignored; no buffer or cursor change.
- Cursor advance after printable:
  - If cur_col < 15: cur_col+1.
  - Else perform a line break.
- Line break:
  - From row 0: cursor to (1,0).
  - From row 1: behaviour depends on the configuration (see Configuration).
- CLEAR:
  - Internal 5-bit index i counts 0..31; each cycle writes 0x20 to cell i (row i[4], column i[3:0]).
  - After i = 31, cursor goes to (0,0) and the state returns to IDLE.
- SCROLL:
  - 4-bit index j counts 0..15; each cycle copies row_b column j to row_a column j and writes 0x20 to row_b column j.
  - After j = 15, cursor goes to (1,0) and the state returns to IDLE.
- Reset: all 32 cells = 0x20, cursor (0,0), state IDLE, ch_ready = 1, busy = 0. Reset mid-CLEAR or mid-SCROLL aborts immediately to this state.

## Timing
- Printable byte accepted at edge N: the cell appears on row_a/row_b and the cursor updates at edge N (registered outputs, visible after N). ch_ready stays 1; one byte per cycle is sustainable.
- Line break by printable at (1,15) under scroll: the character is written at edge N, SCROLL is entered at edge N, and ch_ready = 0 for 16 cycles. ch_ready returns to 1 after edge N+16.
- Form feed accepted at edge N: ch_ready = 0 from N through N+32. The buffer is all spaces and ch_ready = 1 after edge N+32.
- Newline at row 1 under scroll: SCROLL is entered at the accept edge with no character write.
- All outputs are registered, with no combinational path from ch_valid/ch_data to any output.

## Configuration
- Macro LCD_TEXT_SCROLL_EN selects line-break behaviour from row 1.
- Defined: a line break from row 1 (overflow at (1,15) or newline on row 1) enters SCROLL, then the cursor goes to (1,0).
- Undefined: the SCROLL state is not built. A line break from row 1 moves the cursor to (0,0) without modifying the buffer; subsequent writes overwrite row 0. ch_ready only drops for CLEAR.

## Test plan
- Reset, then stream "HELLO" → row_a[127:88] = 0x48454C4C4F, rest 0x20, cursor (0,5), ch_ready held 1.
- 17 × 'A' (0x41) → row_a all 0x41, row_b[127:120] = 0x41, cursor (1,1).
- Fill 32 × 'B', then 'C' with scroll defined → row_a all 0x42, row_b[127:120] = 0x43 after 16 busy cycles, cursor (1,1). Same stimulus without the macro → row_a[127:120] = 0x43, row_b all 0x42, cursor (0,1), no busy.
- "XY", 0x08, 0x08, 0x08 → both cells 0x20, cursor (0,0), third backspace no change; then 0x0A at (1,0) → cursor row 1 handled per configuration.
- 0x0C with ch_valid held high and next byte 'Z' → ch_ready low exactly 32 cycles, buffer all 0x20, 'Z' lands at (0,0).
- Assert rst at CLEAR cycle 10 → immediately all 0x20, cursor (0,0), ch_ready = 1; a 0x07 byte afterwards → no change.
